// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl: releases NUM_DOM active-low domain resets in index order, gap + ready-ack per domain.
// Defining RST_SEQ_WDT_EN adds an ack watchdog that flags seq_err and skips a silent domain.
module reset_seq_ctrl #(
  parameter int NUM_DOM = 4,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 12
) (
  input  logic               clock,
  input  logic               reset_local,
  input  logic               safeshift,
  input  logic               rst_req,
  input  logic [CNT_W-1:0]   dly_cfg,
  input  logic [NUM_DOM-1:0] dom_ack,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               seq_err
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  // ASSERT: all held, capture gap | GAP: count gap | WAIT: await ack[idx] | DONE: all released
  typedef enum logic [1:0] {ASSERT, GAP, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   dly_q, dly_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] rst_q, rst_d;
  logic               err_q, err_d;
  logic               ack_sel;
  logic               timeout;

  assign ack_sel = dom_ack[idx_q];

`ifdef RST_SEQ_WDT_EN
  logic [TMO_W-1:0] wdt_q, wdt_d;

  // Entry to WAIT is always from GAP, so clearing outside WAIT is clearing on entry.
  assign wdt_d   = (state_q == WAIT) ? wdt_q + TMO_W'(1) : '0;
  assign timeout = (state_q == WAIT) && (&wdt_q);

  always_ff @(posedge clock or negedge reset_local) begin
    if (!reset_local) wdt_q <= '0;
    else              wdt_q <= wdt_d;
  end
`else
  assign timeout = (TMO_W < 0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    err_d   = err_q;
    if (rst_req) begin
      state_d = ASSERT;
      rst_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ASSERT: begin
          rst_d   = '0;
          dly_d   = (dly_cfg == '0) ? CNT_W'(1) : dly_cfg;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = GAP;
        end
        GAP: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == dly_q - CNT_W'(1)) begin
            rst_d[idx_q] = 1'b1;
            state_d      = WAIT;
          end
        end
        WAIT: begin
          if (ack_sel || timeout) begin
            if (!ack_sel) err_d = 1'b1;
            if (idx_q == IDX_W'(NUM_DOM - 1)) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              cnt_d   = '0;
              state_d = GAP;
            end
          end
        end
        default: state_d = DONE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_local) begin
    if (!reset_local) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      dly_q   <= CNT_W'(1);
      idx_q   <= '0;
      rst_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      err_q   <= err_d;
    end
  end

  // Shift mode overrides the resets without disturbing the sequence underneath.
  assign dom_rst_n = rst_q | {NUM_DOM{safeshift}};
  assign seq_done  = (state_q == DONE);
  assign seq_busy  = reset_local && (state_q != DONE);
  assign seq_err   = err_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb_reset_seq_ctrl: directed and randomized stimulus checked every cycle against a release-schedule model.
module tb_reset_seq_ctrl;

  localparam int NUM_DOM = 4;
  localparam int CNT_W   = 8;
  localparam int TMO_W   = 8;

  logic               clock = 1'b0;
  logic               reset_local = 1'b0;
  logic               safeshift = 1'b0;
  logic               rst_req = 1'b0;
  logic [CNT_W-1:0]   dly_cfg = 8'd3;
  logic [NUM_DOM-1:0] dom_ack = '1;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic               seq_busy, seq_done, seq_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clock = ~clock;

  reset_seq_ctrl #(.NUM_DOM(NUM_DOM), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clock      (clock),
    .reset_local(reset_local),
    .safeshift  (safeshift),
    .rst_req    (rst_req),
    .dly_cfg    (dly_cfg),
    .dom_ack    (dom_ack),
    .dom_rst_n  (dom_rst_n),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .seq_err    (seq_err)
  );

  // Reference: edge-numbered schedule of release times.
  logic [NUM_DOM-1:0] m_rst;
  bit m_done, m_err, m_wait, m_cap;
  int m_idx, m_dly, m_rel_at, m_wait_start;

  task automatic model_init();
    m_rst  = '0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_wait = 1'b0;
    m_cap  = 1'b1;
    m_idx  = 0;
    m_dly  = 1;
  endtask

  task automatic model_edge();
    bit to;
    to = 1'b0;
    cyc++;
    if (!reset_local) return;
    if (rst_req) begin
      model_init();
    end else if (m_cap) begin
      m_dly    = (dly_cfg == 0) ? 1 : int'(dly_cfg);
      m_rel_at = cyc + m_dly;
      m_cap    = 1'b0;
    end else if (m_done) begin
      m_done = 1'b1;
    end else if (!m_wait) begin
      if (cyc == m_rel_at) begin
        m_rst[m_idx] = 1'b1;
        m_wait       = 1'b1;
        m_wait_start = cyc;
      end
    end else begin
`ifdef RST_SEQ_WDT_EN
      to = ((cyc - m_wait_start) == (1 << TMO_W));
`endif
      if (dom_ack[m_idx] || to) begin
        if (!dom_ack[m_idx]) m_err = 1'b1;
        m_wait = 1'b0;
        if (m_idx == NUM_DOM - 1) begin
          m_done = 1'b1;
        end else begin
          m_idx++;
          m_rel_at = cyc + m_dly;
        end
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    check_val("dom_rst_n", 16'(dom_rst_n), 16'(m_rst | {NUM_DOM{safeshift}}));
    check_val("seq_busy",  16'(seq_busy),  16'(reset_local && !m_done));
    check_val("seq_done",  16'(seq_done),  16'(m_done));
    check_val("seq_err",   16'(seq_err),   16'(m_err));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #2;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_req();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
  endtask

  initial begin
    model_init();
    #1;
    check_all();
    steps(2);
    reset_local = 1'b1;

    // Reset release, dly=3, all acks high: releases at edges 4, 8, 12, 16.
    steps(3);
    check_val("pre_rel0", 16'(dom_rst_n), 16'h0);
    step();
    check_val("rel0", 16'(dom_rst_n), 16'h1);
    steps(4);
    check_val("rel1", 16'(dom_rst_n), 16'h3);
    steps(4);
    check_val("rel2", 16'(dom_rst_n), 16'h7);
    steps(4);
    check_val("rel3", 16'(dom_rst_n), 16'hF);
    check_val("busy_rel3", 16'(seq_busy), 16'h1);
    step();
    check_val("done", 16'(seq_done), 16'h1);
    check_val("idle", 16'(seq_busy), 16'h0);
    steps(3);

    // dly_cfg=0 behaves as 1; a mid-run change to 50 is ignored.
    dly_cfg = 8'd0;
    pulse_req();
    check_val("req_clr", 16'(dom_rst_n), 16'h0);
    check_val("req_done", 16'(seq_done), 16'h0);
    steps(2);
    check_val("z_rel0", 16'(dom_rst_n), 16'h1);
    dly_cfg = 8'd50;
    steps(6);
    check_val("z_rel3", 16'(dom_rst_n), 16'hF);
    step();
    check_val("z_done", 16'(seq_done), 16'h1);

    // Stalled ack on domain 1.
    dly_cfg = 8'd3;
    dom_ack = 4'b1101;
    pulse_req();
    steps(100);
    check_val("stall_rst", 16'(dom_rst_n), 16'h3);
    check_val("stall_busy", 16'(seq_busy), 16'h1);
    dom_ack = 4'hF;
    steps(3);
    check_val("stall_hold", 16'(dom_rst_n), 16'h3);
    step();
    check_val("stall_rel2", 16'(dom_rst_n), 16'h7);
    steps(10);

    // rst_req while waiting on domain 2.
    dly_cfg = 8'd2;
    dom_ack = 4'b1011;
    pulse_req();
    for (int i = 0; i < 40 && !dom_rst_n[2]; i++) step();
    check_val("wait_rel2", 16'(dom_rst_n[2]), 16'h1);
    steps(3);
    pulse_req();
    check_val("rereq_rst", 16'(dom_rst_n), 16'h0);
    check_val("rereq_done", 16'(seq_done), 16'h0);
    dom_ack = 4'hF;
    steps(20);

    // Safeshift during ASSERT.
    dly_cfg = 8'd4;
    pulse_req();
    safeshift = 1'b1;
    #1;
    check_val("ss_on", 16'(dom_rst_n), 16'hF);
    steps(3);
    safeshift = 1'b0;
    #1;
    check_val("ss_off", 16'(dom_rst_n), 16'(m_rst));
    steps(25);

`ifdef RST_SEQ_WDT_EN
    // Watchdog: domain 2 never acks.
    dly_cfg = 8'd1;
    dom_ack = 4'b1011;
    pulse_req();
    steps(300);
    check_val("wdt_err", 16'(seq_err), 16'h1);
    check_val("wdt_done", 16'(seq_done), 16'h1);
    check_val("wdt_rst", 16'(dom_rst_n), 16'hF);
    dom_ack = 4'hF;
    pulse_req();
    check_val("wdt_clr", 16'(seq_err), 16'h0);
    steps(10);
`endif

    // Randomized traffic, including async reset mid-sequence.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) dly_cfg = CNT_W'($urandom_range(0, 4));
      dom_ack   = NUM_DOM'($urandom | $urandom);
      rst_req   = ($urandom_range(0, 59) == 0);
      safeshift = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        reset_local = 1'b0;
        #1;
        model_init();
        check_all();
        step();
        reset_local = 1'b1;
      end
      step();
    end
    rst_req   = 1'b0;
    safeshift = 1'b0;
    steps(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
